// File: rtl/xsp_pkg.sv
// Shared XSP cipher definitions: state encoding, rotate/permute helpers and the
// single-round inverse, used by both the encryption and decryption engines.
package xsp_pkg;

  localparam int XSP_ROT_AMT    = 3;
  localparam int XSP_MAX_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xsp_state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} >> n;
    return t[7:0];
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Inverse round: undo the bit reversal, then the rotate, then the key XOR.
  function automatic logic [7:0] xsp_dec_round(input logic [7:0] data, input logic [7:0] rk);
    return rotr8(bitrev8(data), 3'(XSP_ROT_AMT)) ^ rk;
  endfunction

endpackage

// File: rtl/xsp_dec_round.sv
// Combinational single-round XSP inverse; one instance serves every round of
// the iterative decryption datapath.
module xsp_dec_round
  import xsp_pkg::*;
(
  input  logic [7:0] data,
  input  logic [7:0] rk,
  output logic [7:0] result
);

  assign result = xsp_pkg::xsp_dec_round(data, rk);

endmodule

// File: rtl/xsp_decrypt_stream.sv
// Iterative valid/ready XSP decryption engine, one inverse round per clock.
// Optional completed-handshake counter enabled by defining XSP_DEC_BLKCNT_EN.
module xsp_decrypt_stream
  import xsp_pkg::*;
#(
  parameter int ROUNDS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef XSP_DEC_BLKCNT_EN
  ,
  output logic [15:0] blk_count
`endif
);

  localparam int         CW      = $clog2(ROUNDS + 1);
  localparam logic [2:0] KEY_ROT = 3'((ROUNDS - 1) % 8);

  generate
    if (ROUNDS < 1 || ROUNDS > XSP_MAX_ROUNDS) begin : g_bad_rounds
      $error("xsp_decrypt_stream: ROUNDS out of range 1..16");
    end
  endgenerate

  xsp_state_t    state, next_state;
  logic [7:0]    data_q;
  logic [7:0]    rk_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    round_out;

  xsp_dec_round u_round (
    .data  (data_q),
    .rk    (rk_q),
    .result(round_out)
  );

  // Rounds run last-to-first, so the key starts at the final round's rotation
  // and steps back by one bit each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= 8'h00;
      rk_q   <= 8'h00;
      cnt_q  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            rk_q   <= rotl8(in_key, KEY_ROT);
            cnt_q  <= CW'(ROUNDS);
          end
        end
        RUN: begin
          data_q <= round_out;
          rk_q   <= rotr8(rk_q, 3'd1);
          cnt_q  <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(1)) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_data = data_q;

`ifdef XSP_DEC_BLKCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         blk_count <= 16'h0000;
    else if (out_valid && out_ready) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule
